sort4_stream: RTL



---
 rtl/sort4_stream.sv | 104 ++++++++++
 1 files changed

// File: rtl/sort4_stream.sv
// Serial-in/serial-out 4-element sorter: loads four words, sorts them in place
// with one shared compare-swap unit over five cycles, then streams them out.
module sort4_stream #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {LOAD, SORT, SEND} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q [4];
  logic [1:0]       idx_q;
  logic [2:0]       step_q;

  logic [1:0]       a_d, b_d;
  logic             swap_d;

  always_comb begin
    a_d = 2'd1;
    b_d = 2'd2;
    case (step_q)
      3'd0:    begin a_d = 2'd0; b_d = 2'd1; end
      3'd1:    begin a_d = 2'd2; b_d = 2'd3; end
      3'd2:    begin a_d = 2'd0; b_d = 2'd2; end
      3'd3:    begin a_d = 2'd1; b_d = 2'd3; end
      default: begin a_d = 2'd1; b_d = 2'd2; end
    endcase
    swap_d = DESCEND ? (r_q[a_d] < r_q[b_d]) : (r_q[a_d] > r_q[b_d]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      step_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid && in_ready) begin
            r_q[idx_q] <= in_data;
            idx_q      <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              idx_q    <= '0;
              step_q   <= '0;
              state_q  <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        SORT: begin
          if (swap_d) begin
            r_q[a_d] <= r_q[b_d];
            r_q[b_d] <= r_q[a_d];
          end
          if (step_q == 3'd4) begin
            // The last pair (1,2) never touches r[0], so it can be presented now.
            state_q   <= SEND;
            idx_q     <= '0;
            out_valid <= 1'b1;
            out_data  <= r_q[0];
            out_last  <= 1'b0;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (idx_q == 2'd3) begin
              state_q   <= LOAD;
              idx_q     <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx_q    <= idx_q + 2'd1;
              out_data <= r_q[idx_q + 2'd1];
              out_last <= (idx_q == 2'd2);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule
